// File: rtl/ark_pkg.sv
// ark_pkg: shared definitions for the AddRoundKey round sequencer.
//   - ark_state_e : sequencer FSM states (IDLE, RUN, LAST)
//   - KL_*        : key-length codes carried on the key_len input
//   - NR_*        : AES round counts for each legal key length
//   - nr_of()     : key_len code -> round count Nr (0 for the illegal code)
package ark_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } ark_state_e;

    localparam logic [1:0] KL_128     = 2'd0;
    localparam logic [1:0] KL_192     = 2'd1;
    localparam logic [1:0] KL_256     = 2'd2;
    localparam logic [1:0] KL_ILLEGAL = 2'd3;

    localparam int unsigned NR_128 = 32'd10;
    localparam int unsigned NR_192 = 32'd12;
    localparam int unsigned NR_256 = 32'd14;

    // Round count for a key-length code; the illegal code maps to 0 so a
    // stray use can never extend a pass.
    function automatic int unsigned nr_of(input logic [1:0] key_len);
        int unsigned nr;
        case (key_len)
            KL_128:  nr = NR_128;
            KL_192:  nr = NR_192;
            KL_256:  nr = NR_256;
            default: nr = 32'd0;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/ark_out_reg.sv
// ark_out_reg: single-entry valid/ready output register with a last flag.
//   clk, rst      : clock, asynchronous active-low reset
//   flush         : drop any held result (valid and last cleared)
//   load          : capture load_data/load_last; may coincide with a
//                   downstream accept so the slot is refilled with no bubble
//   out_data/out_valid/out_last/out_ready : downstream handshake
//   slot_free     : the register can take a new result this cycle
module ark_out_reg
    import ark_pkg::*;
#(
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_data,
    input  logic               load_last,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic               slot_free
);

    logic [BLOCK_W-1:0] data_r;
    logic               valid_r;
    logic               last_r;

    assign out_data  = data_r;
    assign out_valid = valid_r;
    assign out_last  = last_r;

    // Empty, or being drained this cycle: either way a new result fits.
    assign slot_free = !valid_r || out_ready;

    // Output slot: flush beats load, load beats drain, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r  <= {BLOCK_W{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (load) begin
            data_r  <= load_data;
            valid_r <= 1'b1;
            last_r  <= load_last;
        end else if (valid_r && out_ready) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
            last_r  <= last_r;
        end
    end

endmodule

// File: rtl/ark_round_sequencer.sv
// ark_round_sequencer: drives one AES cipher pass (encrypt or decrypt,
// AES-128/192/256) through the AddRoundKey stage. Each round it asks the
// key schedule for the right round-key index, XORs that key into the state
// coming from the round datapath and emits the result with a last-round
// flag; a done pulse marks the end of the pass.
//   clk, rst                      : clock, asynchronous active-low reset
//   start, mode, key_len          : pass request, sampled only in IDLE
//   abort                         : synchronous cancel of a running pass
//   st_data/st_valid/st_ready     : state input handshake
//   rk_req/rk_idx/rk_data/rk_valid: round-key request and response
//   out_data/out_valid/out_ready/out_last : result handshake
//   round, busy, done, err        : status
module ark_round_sequencer
    import ark_pkg::*;
#(
    parameter int BLOCK_W = 128,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [1:0]         key_len,
    input  logic               abort,
    input  logic [BLOCK_W-1:0] st_data,
    input  logic               st_valid,
    output logic               st_ready,
    output logic               rk_req,
    output logic [ROUND_W-1:0] rk_idx,
    input  logic [BLOCK_W-1:0] rk_data,
    input  logic               rk_valid,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic [ROUND_W-1:0] round,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // Encrypt walks keys 0..Nr, decrypt walks Nr..0 for the same round count.
    function automatic logic [ROUND_W-1:0] key_index(
        input logic               m,
        input logic [ROUND_W-1:0] nr,
        input logic [ROUND_W-1:0] rnd
    );
        logic [ROUND_W-1:0] idx;
        if (m) begin
            idx = nr - rnd;
        end else begin
            idx = rnd;
        end
        return idx;
    endfunction

    ark_state_e         state_r;
    ark_state_e         state_nxt_s;

    logic               mode_r;
    logic               mode_nxt_s;
    logic [ROUND_W-1:0] nr_r;
    logic [ROUND_W-1:0] nr_nxt_s;
    logic [ROUND_W-1:0] nr_dec_s;
    logic [ROUND_W-1:0] round_r;
    logic [ROUND_W-1:0] round_nxt_s;
    logic [ROUND_W-1:0] rk_idx_r;
    logic               busy_r;
    logic               done_r;
    logic               done_nxt_s;
    logic               err_r;
    logic               err_nxt_s;

    logic               rk_req_s;
    logic               st_ready_s;
    logic               fire_s;
    logic               abort_s;
    logic               last_round_s;
    logic               slot_free_s;
    logic               out_take_s;
    logic               out_valid_s;

    assign nr_dec_s     = ROUND_W'(nr_of(key_len));
    // abort is meaningless while idle, so it is only honoured mid-pass.
    assign abort_s      = abort && (state_r != IDLE);
    assign last_round_s = (round_r == nr_r);
    assign fire_s       = st_valid && st_ready_s;
    assign out_take_s   = out_valid_s && out_ready;

    assign st_ready  = st_ready_s;
    assign rk_req    = rk_req_s;
    assign rk_idx    = rk_idx_r;
    assign round     = round_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign out_valid = out_valid_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state plus the handshake strobes toward datapath and key schedule.
    always_comb begin
        state_nxt_s = state_r;
        rk_req_s    = 1'b0;
        st_ready_s  = 1'b0;
        if (abort_s) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && (key_len != KL_ILLEGAL)) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RUN: begin
                    // Only ask for / accept work when the result has somewhere to go.
                    rk_req_s   = slot_free_s;
                    st_ready_s = rk_valid && slot_free_s;
                    if (st_valid && st_ready_s && last_round_s) begin
                        state_nxt_s = LAST;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                LAST: begin
                    if (out_take_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = LAST;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Next pass context (mode, Nr, round) and the done/err pulse requests.
    always_comb begin
        mode_nxt_s  = mode_r;
        nr_nxt_s    = nr_r;
        round_nxt_s = round_r;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        if (abort_s) begin
            round_nxt_s = {ROUND_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && (key_len != KL_ILLEGAL)) begin
                        mode_nxt_s  = mode;
                        nr_nxt_s    = nr_dec_s;
                        round_nxt_s = {ROUND_W{1'b0}};
                    end else if (start) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        round_nxt_s = round_r;
                    end
                end
                RUN: begin
                    // The final round holds its count until the result drains in LAST.
                    if (fire_s && !last_round_s) begin
                        round_nxt_s = round_r + ROUND_W'(1);
                    end else begin
                        round_nxt_s = round_r;
                    end
                end
                LAST: begin
                    if (out_take_s) begin
                        round_nxt_s = {ROUND_W{1'b0}};
                        done_nxt_s  = 1'b1;
                    end else begin
                        round_nxt_s = round_r;
                    end
                end
                default: begin
                    round_nxt_s = {ROUND_W{1'b0}};
                end
            endcase
        end
    end

    // Pass context and status registers; rk_idx is precomputed from the next
    // context so the key request never depends combinationally on inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r   <= 1'b0;
            nr_r     <= {ROUND_W{1'b0}};
            round_r  <= {ROUND_W{1'b0}};
            rk_idx_r <= {ROUND_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            mode_r   <= mode_nxt_s;
            nr_r     <= nr_nxt_s;
            round_r  <= round_nxt_s;
            rk_idx_r <= key_index(mode_nxt_s, nr_nxt_s, round_nxt_s);
            busy_r   <= (state_nxt_s != IDLE);
            done_r   <= done_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

    ark_out_reg #(
        .BLOCK_W (BLOCK_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort_s),
        .load      (fire_s),
        .load_data (st_data ^ rk_data),
        .load_last (last_round_s),
        .out_data  (out_data),
        .out_valid (out_valid_s),
        .out_last  (out_last),
        .out_ready (out_ready),
        .slot_free (slot_free_s)
    );

endmodule

// File: tb/tb_ark_round_sequencer.sv
// Scoreboard bench for ark_round_sequencer. The stimulus side plays both the
// round datapath and the key schedule (a random key table per pass) and, on
// every accepted state, pushes the expected result computed as
// state XOR key[expected index]. A separate monitor pops and compares on
// every accepted output and tracks the done pulse and per-pass output count.
module tb_ark_round_sequencer;

    localparam logic [127:0] PT0  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT0  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [1:0]   key_len;
    logic         abort;
    logic [127:0] st_data;
    logic         st_valid;
    logic         st_ready;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         rk_valid;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic [3:0]   round;
    logic         busy;
    logic         done;
    logic         err;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    exp_t         sb_q[$];
    logic [127:0] keys [16];
    int           n_chk     = 0;
    int           n_fail    = 0;
    int           pass_nr   = 10;
    int           done_seen = 0;
    int           out_cnt   = 0;

    always #5 clk = ~clk;

    ark_round_sequencer #(.BLOCK_W(128), .ROUND_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .key_len   (key_len),
        .abort     (abort),
        .st_data   (st_data),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .rk_req    (rk_req),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .rk_valid  (rk_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .round     (round),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int nr_model(input logic [1:0] kl);
        return (kl == 2'd0) ? 10 : (kl == 2'd1) ? 12 : 14;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_out_data"},  out_data,        128'd0);
        chk({tag, "_out_last"},  128'(out_last),  128'd0);
        chk({tag, "_round"},     128'(round),     128'd0);
        chk({tag, "_busy"},      128'(busy),      128'd0);
        chk({tag, "_done"},      128'(done),      128'd0);
        chk({tag, "_err"},       128'(err),       128'd0);
        chk({tag, "_rk_req"},    128'(rk_req),    128'd0);
        chk({tag, "_st_ready"},  128'(st_ready),  128'd0);
        chk({tag, "_rk_idx"},    128'(rk_idx),    128'd0);
    endtask

    // One pass. known: first round uses the FIPS-197 vector; bp: 5-cycle
    // output stall after the 4th round then full throughput; abort_at/rst_at:
    // cancel by abort / async reset once that many rounds were accepted.
    task automatic run_pass(input logic m, input logic [1:0] kl, input bit known,
                            input bit bp, input int abort_at, input int rst_at);
        int           k = 0;
        int           bp_cnt = 0;
        int           done0;
        int           exp_idx;
        bit           lat_chk = 1'b0;
        bit           in_bp;
        logic [127:0] held = 128'd0;
        exp_t         e;
        pass_nr = nr_model(kl);
        for (int i = 0; i < 16; i++) keys[i] = rnd128();
        if (known) keys[0] = KEY0;
        done0 = done_seen;
        for (int budget = 0; budget < 3000 && done_seen == done0; budget++) begin
            @(posedge clk); #1;
            start   = (budget == 0);
            mode    = (budget == 0) ? m : 1'($urandom);
            key_len = (budget == 0) ? kl : 2'($urandom);
            if (abort_at > 0 && k == abort_at) begin
                st_valid = 1'b0; rk_valid = 1'b0; out_ready = 1'b0; abort = 1'b1;
                @(negedge clk);
                chk("pre_abort_round",     128'(round),     128'(abort_at));
                chk("pre_abort_out_valid", 128'(out_valid), 128'd1);
                @(posedge clk); #1;
                abort = 1'b0;
                chk("abort_busy",      128'(busy),      128'd0);
                chk("abort_out_valid", 128'(out_valid), 128'd0);
                chk("abort_out_last",  128'(out_last),  128'd0);
                chk("abort_round",     128'(round),     128'd0);
                return;
            end
            if (rst_at > 0 && k == rst_at) begin
                st_valid = 1'b0; rk_valid = 1'b0; out_ready = 1'b0;
                #2 rst = 1'b0;
                #1 check_idle("async_reset");
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                return;
            end
            in_bp = bp && (k >= 4) && (bp_cnt < 5);
            if (in_bp) begin
                st_valid = 1'b1; rk_valid = 1'b1; out_ready = 1'b0;
            end else if (bp && bp_cnt >= 5) begin
                st_valid = 1'b1; rk_valid = 1'b1; out_ready = 1'b1;
            end else begin
                st_valid  = ($urandom % 4) != 0;
                rk_valid  = ($urandom % 4) != 0;
                out_ready = ($urandom % 3) != 0;
            end
            st_data = (known && k == 0) ? PT0 : rnd128();
            rk_data = rk_valid ? keys[rk_idx] : rnd128();
            @(negedge clk);
            if (budget == 1) chk("busy_after_start", 128'(busy), 128'd1);
            if (lat_chk) begin
                chk("latency_out_valid", 128'(out_valid), 128'd1);
                chk("fips_round0_data",  out_data,        CT0);
                lat_chk = 1'b0;
            end
            if (in_bp) begin
                chk("bp_st_ready", 128'(st_ready), 128'd0);
                chk("bp_rk_req",   128'(rk_req),   128'd0);
                if (bp_cnt == 0) held = out_data;
                else chk("bp_out_data_stable", out_data, held);
                bp_cnt++;
            end else if (bp && bp_cnt >= 5 && k <= pass_nr) begin
                chk("no_bubble_st_ready",  128'(st_ready),  128'd1);
                chk("no_bubble_out_valid", 128'(out_valid), 128'd1);
            end
            chk("st_ready_needs_key", 128'(st_ready & ~rk_valid), 128'd0);
            if (st_valid && st_ready) begin
                exp_idx = m ? (pass_nr - k) : k;
                chk("rk_idx", 128'(rk_idx), 128'(exp_idx));
                e.data = (known && k == 0) ? CT0 : (st_data ^ keys[4'(exp_idx)]);
                e.last = (k == pass_nr);
                sb_q.push_back(e);
                if (known && k == 0) lat_chk = 1'b1;
                k++;
            end
            #1;
        end
        if (abort_at == 0 && rst_at == 0)
            chk("pass_completed", 128'(done_seen - done0), 128'd1);
        start = 1'b0; st_valid = 1'b0; rk_valid = 1'b0; out_ready = 1'b0;
    endtask

    // Monitor: output scoreboard, done pulse timing and outputs per pass.
    initial begin
        exp_t e;
        bit   exp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                exp_done = 1'b0;
            end else begin
                chk("done_pulse", 128'(done), 128'(exp_done));
                if (exp_done) begin
                    chk("outputs_per_pass", 128'(out_cnt), 128'(pass_nr + 1));
                    done_seen++;
                end
                exp_done = 1'b0;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("out_valid_without_expected", 128'(out_valid), 128'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_last", 128'(out_last), 128'(e.last));
                        out_cnt++;
                        if (e.last) begin
                            chk("round_at_last", 128'(round), 128'(pass_nr));
                            exp_done = 1'b1;
                        end
                    end
                end
                if (!busy) begin
                    out_cnt = 0;
                    sb_q.delete();
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; key_len = 2'd0; abort = 1'b0;
        st_data = 128'd0; st_valid = 1'b0; rk_data = 128'd0; rk_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #10 check_idle("reset");
        @(posedge clk); #1 rst = 1'b1;

        run_pass(1'b0, 2'd0, 1'b1, 1'b1, 0, 0);
        run_pass(1'b1, 2'd2, 1'b0, 1'b0, 0, 0);

        // Illegal key length: one err pulse, never leaves IDLE.
        @(posedge clk); #1;
        start = 1'b1; key_len = 2'd3; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; key_len = 2'd0;
        @(negedge clk);
        chk("err_pulse",    128'(err),    128'd1);
        chk("err_busy",     128'(busy),   128'd0);
        chk("err_rk_req",   128'(rk_req), 128'd0);
        @(negedge clk);
        chk("err_one_cycle", 128'(err),   128'd0);
        chk("err_busy_after", 128'(busy), 128'd0);

        for (int i = 0; i < 4; i++)
            run_pass(1'($urandom), 2'($urandom_range(0, 2)), 1'b0, 1'b0, 0, 0);

        run_pass(1'b0, 2'd1, 1'b0, 1'b0, 6, 0);
        repeat (2) @(posedge clk);
        run_pass(1'b0, 2'd1, 1'b0, 1'b0, 0, 0);

        run_pass(1'b1, 2'd0, 1'b0, 1'b0, 0, 5);
        run_pass(1'b0, 2'd2, 1'b0, 1'b0, 0, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ark_round_sequencer.md
Name: ark_round_sequencer

Overview:
- Parametrised successor to the single-purpose round-key XOR stage.
- Sequences a full AES cipher pass, encrypt or decrypt, for AES-128/192/256.
- Each round it requests the correct round-key index from the key-expansion block, XORs the key with the incoming state under valid/ready handshakes, and emits the result with a last-round flag and a done pulse.
- Sits between the round datapath (SubBytes/ShiftRows/MixColumns and their inverses) and the key schedule.

Parameters:
- BLOCK_W, 128: state/round-key width in bits; must be a multiple of 32.
- ROUND_W, 4: width of the round counter and key index; must hold 14.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a pass; sampled only in IDLE.
- mode  in  1  0 = encrypt, 1 = decrypt; latched on start.
- key_len  in  2  0 = 128 (Nr=10), 1 = 192 (Nr=12), 2 = 256 (Nr=14), 3 = illegal; latched on start.
- abort  in  1  synchronous cancel.
- st_data  in  BLOCK_W  state from round datapath.
- st_valid  in  1  st_data valid.
- st_ready  out  1  state accepted this cycle when st_valid is also high.
- rk_req  out  1  round key requested.
- rk_idx  out  ROUND_W  requested round-key index.
- rk_data  in  BLOCK_W  round key for rk_idx.
- rk_valid  in  1  rk_data valid for the current rk_idx.
- out_data  out  BLOCK_W  st_data XOR rk_data, registered.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  out_data belongs to the final round.
- round  out  ROUND_W  current round, 0..Nr.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a pass completes.
- err  out  1  one-cycle pulse on start with key_len = 3.

Behaviour:
- Reset (async, rst low): state IDLE; all outputs 0; latched mode/Nr cleared.
- Nr decode: from key_len via package constants; latched on start.
- Index: rk_idx = round when mode = 0, Nr − round when mode = 1. rk_idx is driven from registers only.
- Free output slot: slot_free = !out_valid || out_ready.
- FSM states:
  - IDLE: start with key_len != 3 → latch mode and Nr, round = 0 → RUN. start with key_len = 3 → err pulse next cycle, stay IDLE. start is ignored in every other state.
  - RUN:
    - rk_req = slot_free.
    - st_ready = rk_valid && slot_free.
    - fire = st_valid && st_ready.
    - On fire: out_data <= st_data ^ rk_data; out_valid <= 1; out_last <= (round == Nr).
    - If round == Nr, go to LAST (round holds). Otherwise round increments.
    - No fire: all registers hold.
  - LAST: rk_req = 0, st_ready = 0. When out_valid && out_ready: out_valid <= 0, out_last <= 0, done pulses next cycle, round <= 0 → IDLE.
- Output register:
  - out_valid clears on out_ready when there is no simultaneous fire.
  - Fire together with out_ready replaces the data with no bubble, giving 1 result per cycle.
- Latency: 1 cycle from fire to out_valid.
- A pass produces exactly Nr+1 outputs: 11, 13 or 15.
- abort: highest priority in any state. Next cycle: IDLE, out_valid = 0, out_last = 0, round = 0, no done pulse. abort in IDLE has no effect.
- rk_valid deasserting mid-round stalls the round. rk_data must stay stable while rk_valid = 1 and rk_idx is unchanged.
- Back-to-back passes: start is accepted in the cycle after returning to IDLE.

Decomposition:
- Package ark_pkg holds:
  - state enum {IDLE, RUN, LAST};
  - key-length codes KL_128/192/256/ILLEGAL;
  - NR_128 = 10, NR_192 = 12, NR_256 = 14;
  - function nr_of(key_len).
- One natural sub-module: ark_out_reg, the BLOCK_W valid/ready output register with last flag.

Test Plan:
- AES-128 encrypt, round 0: st_data 3243f6a8885a308d313198a2e0370734, rk_data 2b7e151628aed2a6abf7158809cf4f3c at rk_idx 0 → out_data 193de3bea0f4e22b9ac68d2ae9f84808, 1 cycle after fire; 11 outputs total; out_last only on the 11th; done one cycle after the 11th is accepted.
- AES-256 decrypt: rk_idx sequence 14, 13 … 0 observed. Exactly 15 outputs. round ends at 14 before returning to 0.
- Backpressure: out_ready low for 5 cycles mid-pass → st_ready = 0, rk_req = 0, out_data stable. out_ready held high afterwards → one output per cycle, no bubbles.
- key_len = 3 with start → err pulses for 1 cycle, busy stays 0, no rk_req.
- abort asserted in RUN at round 6 of AES-192, with out_valid = 1 → next cycle busy = 0, out_valid = 0, round = 0, no done. A new start then runs cleanly from round 0.
- rst pulsed low mid-pass (asynchronous, between clock edges) → all outputs 0 immediately. start after rst release runs a full pass.
